// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/execute/memory/writeback sequencing.
// Optional retired-instruction counter on output `instret` when CTRL_INSTRET_EN is defined.
module multicycle_ctrl #(
   parameter bit RESET_FETCH = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [6:0] opcode,
   input  logic       br_taken,
   output logic       imem_req,
   input  logic       imem_ready,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_ready,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic [1:0] alu_a_sel,
   output logic       alu_b_sel,
   output logic       rf_we,
   output logic [1:0] wb_sel,
   output logic       illegal,
   output logic [2:0] state
`ifdef CTRL_INSTRET_EN
   ,
   output logic [63:0] instret
`endif
);

   typedef enum logic [2:0] {
      StHalt   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StTrap   = 3'd6
   } state_e;

   localparam logic [6:0] OpR      = 7'b0110011;
   localparam logic [6:0] OpImm    = 7'b0010011;
   localparam logic [6:0] OpLoad   = 7'b0000011;
   localparam logic [6:0] OpStore  = 7'b0100011;
   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [6:0] OpLui    = 7'b0110111;
   localparam logic [6:0] OpAuipc  = 7'b0010111;

   state_e     state_q;
   logic       illegal_q;
   logic       is_legal;
   logic [1:0] a_sel;
   logic       b_sel;

   always_comb begin
      is_legal = 1'b0;
      case (opcode)
         OpR, OpImm, OpLoad, OpStore, OpBranch, OpJal, OpJalr, OpLui, OpAuipc: is_legal = 1'b1;
         default: is_legal = 1'b0;
      endcase
   end

   // Operand selects are valid only once the opcode has been decoded as legal.
   always_comb begin
      a_sel = 2'd0;
      b_sel = 1'b1;
      case (opcode)
         OpR, OpBranch:  b_sel = 1'b0;
         OpJal, OpAuipc: a_sel = 2'd1;
         OpLui:          a_sel = 2'd2;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RESET_FETCH ? StFetch : StHalt;
         illegal_q <= 1'b0;
      end else begin
         case (state_q)
            StHalt:   if (start) state_q <= StFetch;
            StFetch:  if (imem_ready) state_q <= StDecode;
            StDecode: begin
               if (is_legal) begin
                  state_q <= StExec;
               end else begin
                  state_q   <= StTrap;
                  illegal_q <= 1'b1;
               end
            end
            StExec: begin
               if (opcode == OpBranch) state_q <= StFetch;
               else if (opcode == OpLoad || opcode == OpStore) state_q <= StMem;
               else state_q <= StWb;
            end
            StMem: begin
               if (dmem_ready) state_q <= (opcode == OpStore) ? StFetch : StWb;
            end
            StWb:   state_q <= StFetch;
            StTrap: state_q <= StTrap;
            default: state_q <= StHalt;
         endcase
      end
   end

   // Outputs are forced low while reset is asserted, so a pending request drops immediately.
   always_comb begin
      imem_req  = 1'b0;
      dmem_req  = 1'b0;
      dmem_we   = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_sel    = 2'd0;
      alu_a_sel = 2'd0;
      alu_b_sel = 1'b0;
      rf_we     = 1'b0;
      wb_sel    = 2'd0;
      if (!rst) begin
         case (state_q)
            StFetch: begin
               imem_req = 1'b1;
               ir_we    = imem_ready;
            end
            StExec: begin
               alu_a_sel = a_sel;
               alu_b_sel = b_sel;
               if (opcode == OpBranch) begin
                  pc_we  = 1'b1;
                  pc_sel = br_taken ? 2'd1 : 2'd0;
               end
            end
            StMem: begin
               alu_a_sel = a_sel;
               alu_b_sel = b_sel;
               dmem_req  = 1'b1;
               dmem_we   = (opcode == OpStore);
               pc_we     = dmem_ready && (opcode == OpStore);
            end
            StWb: begin
               alu_a_sel = a_sel;
               alu_b_sel = b_sel;
               rf_we     = 1'b1;
               pc_we     = 1'b1;
               if (opcode == OpLoad) wb_sel = 2'd1;
               else if (opcode == OpJal || opcode == OpJalr) wb_sel = 2'd2;
               if (opcode == OpJal) pc_sel = 2'd1;
               else if (opcode == OpJalr) pc_sel = 2'd2;
            end
            default: ;
         endcase
      end
   end

   assign illegal = illegal_q;
   assign state   = state_q;

`ifdef CTRL_INSTRET_EN
   logic [63:0] instret_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) instret_q <= 64'd0;
      else if (pc_we) instret_q <= instret_q + 64'd1;
   end

   assign instret = instret_q;
`else
   // No retired-instruction counter in this build.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized self-checking bench for multicycle_ctrl against a phase-level reference model.
// Checks instret as well when CTRL_INSTRET_EN is defined.
module tb_multicycle_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [6:0] opcode = 7'd0;
   logic       br_taken = 1'b0;
   logic       imem_ready = 1'b0;
   logic       dmem_ready = 1'b0;
   logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, alu_b_sel, rf_we, illegal;
   logic [1:0] pc_sel, alu_a_sel, wb_sel;
   logic [2:0] state;
`ifdef CTRL_INSTRET_EN
   logic [63:0] instret;
`endif

   multicycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .opcode     (opcode),
      .br_taken   (br_taken),
      .imem_req   (imem_req),
      .imem_ready (imem_ready),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ready (dmem_ready),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_sel     (pc_sel),
      .alu_a_sel  (alu_a_sel),
      .alu_b_sel  (alu_b_sel),
      .rf_we      (rf_we),
      .wb_sel     (wb_sel),
      .illegal    (illegal),
      .state      (state)
`ifdef CTRL_INSTRET_EN
      ,
      .instret    (instret)
`endif
   );

   always #5 clk = ~clk;

   logic [16:0] obs;
   assign obs = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, alu_a_sel, alu_b_sel,
                 rf_we, wb_sel, illegal};

   int unsigned     n_chk = 0;
   int unsigned     n_pass = 0;
   longint unsigned retired = 0;

   localparam int KR = 0, KI = 1, KLD = 2, KST = 3, KBR = 4, KJAL = 5, KJALR = 6, KLUI = 7;
   localparam int KAUIPC = 8, KILL = 9;

   logic [6:0] ops [10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b0000000};

   typedef struct {
      logic [16:0] v;
      bit          ir;
      bit          dr;
      bit          bt;
   } step_t;

   step_t q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [16:0] mk(input int st, input bit ireq, input bit dreq, input bit dwe,
                                      input bit irw, input bit pcw, input int pcs, input int as,
                                      input bit bs, input bit rfw, input int wbs, input bit ill);
      return {st[2:0], ireq, dreq, dwe, irw, pcw, pcs[1:0], as[1:0], bs, rfw, wbs[1:0], ill};
   endfunction

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic void push(input logic [16:0] v, input bit ir, input bit dr, input bit bt);
      step_t s;
      s.v  = v;
      s.ir = ir;
      s.dr = dr;
      s.bt = bt;
      q.push_back(s);
   endfunction

   // Expected per-cycle trace of one instruction, phase by phase.
   function automatic void build(input int kind, input int iw, input int dw, input bit br);
      bit is_ld = (kind == KLD);
      bit is_st = (kind == KST);
      bit is_br = (kind == KBR);
      bit is_jal = (kind == KJAL);
      bit is_jalr = (kind == KJALR);
      int a = (kind == KJAL || kind == KAUIPC) ? 1 : (kind == KLUI ? 2 : 0);
      bit b = !(kind == KR || kind == KBR);
      q.delete();
      for (int i = 0; i < iw; i++) push(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 0, rb(), rb());
      push(mk(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0), 1, rb(), rb());
      push(mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), rb(), rb(), rb());
      if (kind == KILL) begin
         for (int i = 0; i < 20; i++) push(mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), rb(), rb(), rb());
         return;
      end
      push(mk(3, 0, 0, 0, 0, is_br, (is_br && br) ? 1 : 0, a, b, 0, 0, 0), rb(), rb(), br);
      if (is_ld || is_st) begin
         for (int i = 0; i < dw; i++) push(mk(4, 0, 1, is_st, 0, 0, 0, a, b, 0, 0, 0), rb(), 0, rb());
         push(mk(4, 0, 1, is_st, 0, is_st, 0, a, b, 0, 0, 0), rb(), 1, rb());
      end
      if (!(is_st || is_br)) begin
         push(mk(5, 0, 0, 0, 0, 1, is_jal ? 1 : (is_jalr ? 2 : 0), a, b, 1,
                 is_ld ? 1 : ((is_jal || is_jalr) ? 2 : 0), 0), rb(), rb(), rb());
      end
   endfunction

   task automatic run_instr(input int kind, input int iw, input int dw, input bit br,
                            input string tag);
      int pcw = 0;
      opcode = ops[kind];
      build(kind, iw, dw, br);
      foreach (q[i]) begin
         @(negedge clk);
         imem_ready = q[i].ir;
         dmem_ready = q[i].dr;
         br_taken   = q[i].bt;
         start      = rb();
         #1;
         check($sformatf("%s cyc%0d", tag, i), obs, q[i].v);
         pcw += int'(pc_we);
      end
      check($sformatf("%s pc_we pulses", tag), pcw, (kind == KILL) ? 0 : 1);
      if (kind != KILL) retired++;
      @(posedge clk);
      #1;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
`ifdef CTRL_INSTRET_EN
      check($sformatf("%s instret", tag), instret, retired);
`endif
   endtask

   initial begin
      @(negedge clk);
      #1;
      check("reset outputs", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      rst = 1'b0;
      #1;
      check("first fetch", obs, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      run_instr(KI, 0, 0, 0, "addi");
      run_instr(KLD, 0, 3, 0, "lw_wait3");
      run_instr(KBR, 0, 0, 1, "beq_taken");
      run_instr(KBR, 1, 0, 0, "beq_not");
      run_instr(KJALR, 0, 0, 0, "jalr");
      run_instr(KST, 0, 0, 0, "sw");

      // Reset while a load is waiting in MEM.
      opcode = ops[KLD];
      @(negedge clk) imem_ready = 1'b1;
      @(negedge clk) imem_ready = 1'b0;
      @(negedge clk);
      @(negedge clk) dmem_ready = 1'b0;
      #1;
      check("mem pending", {state, dmem_req}, {3'd4, 1'b1});
      rst = 1'b1;
      #1;
      check("reset in mem", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      retired = 0;
`ifdef CTRL_INSTRET_EN
      check("reset instret", instret, 64'd0);
`endif
      @(negedge clk) rst = 1'b0;
      #1;
      check("fetch after reset", obs, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      for (int n = 0; n < 40; n++) begin
         run_instr($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, 3), rb(),
                   $sformatf("rnd%0d", n));
      end

      run_instr(KILL, 1, 0, 0, "trap");
`ifdef CTRL_INSTRET_EN
      check("trap instret frozen", instret, retired);
`endif
      rst = 1'b1;
      #1;
      check("trap cleared by reset", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk) rst = 1'b0;
      #1;
      check("fetch after trap", obs, mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback around the instruction decoder, ALU, register file and PC.
- Consumes the opcode field of the instruction register and the ALU branch result.
- Drives all datapath enables and muxes, plus req/ready handshakes to instruction and data memory.

Parameters:
- RESET_FETCH, 1, 1 = leave reset straight into FETCH; 0 = park in HALT until `start` pulses.

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  leaves HALT when RESET_FETCH=0; ignored in other states
- opcode  input  7  instruction[6:0] from the instruction register
- br_taken  input  1  ALU branch-condition result, valid in EXECUTE
- imem_req  output  1  instruction fetch request
- imem_ready  input  1  fetch data valid and accepted this cycle
- dmem_req  output  1  data memory request
- dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1
- dmem_ready  input  1  data access complete this cycle
- ir_we  output  1  load instruction register
- pc_we  output  1  update PC
- pc_sel  output  2  0: pc+4, 1: pc+imm, 2: ALU result with bit0 cleared (JALR)
- alu_a_sel  output  2  0: rs1, 1: pc, 2: zero
- alu_b_sel  output  1  0: rs2, 1: imm
- rf_we  output  1  register file write enable
- wb_sel  output  2  0: ALU, 1: load data, 2: pc+4
- illegal  output  1  sticky illegal-opcode flag
- state  output  3  current state encoding, for debug

Behaviour:
- Reset: asynchronous, active-high; any cycle, including mid-handshake.
  - State goes to FETCH (RESET_FETCH=1) or HALT (RESET_FETCH=0).
  - All outputs are 0, `illegal` clears, and any outstanding request is abandoned.
- State encoding: HALT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Handshake rules:
  - A request stays high until the matching ready is sampled high.
  - ready while the request is low is ignored.
  - req and ready may be high in the same cycle.
- FETCH: imem_req=1.
  - On imem_ready: ir_we=1 in that same cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, all strobes 0.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111.
  - Any other opcode: next state TRAP.
- EXEC: alu_a_sel/alu_b_sel set per opcode.
  - R: (0,0). I/LOAD/STORE/JALR: (0,1). AUIPC/JAL: (1,1). LUI: (2,1). BRANCH: (0,0).
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0; next state FETCH.
  - LOAD/STORE: next state MEM.
  - All other legal opcodes: next state WB.
- MEM: dmem_req=1; dmem_we=1 only for STORE. ALU selects are held from EXEC.
  - On dmem_ready with STORE: pc_we=1, pc_sel=0, next state FETCH.
  - On dmem_ready with LOAD: next state WB.
  - Otherwise stay in MEM.
- WB: rf_we=1 and pc_we=1; next state FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 0 otherwise.
  - pc_sel: 1 for JAL, 2 for JALR, 0 otherwise.
  - x0 writes are suppressed by the register file, not by this block.
- TRAP: illegal=1, all strobes 0; held until reset. `start` is ignored.
- Outputs are combinational from the current state and opcode. opcode is stable from DECODE until the next ir_we.
- Latency with zero-wait memory, counted from the first FETCH cycle to the first cycle of the next FETCH:
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH: 3 cycles.
- Each memory wait cycle adds one cycle.
- Exactly one pc_we pulse per retired instruction.

Optional Feature:
- Macro: CTRL_INSTRET_EN.
- Defined:
  - Adds output `instret` [63:0], reset to 0.
  - Increments by 1 in every cycle where pc_we=1.
  - Wraps from all-ones to 0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset during MEM with dmem_req=1 (load pending) -> same cycle: all outputs 0, state=1; next cycle: imem_req=1.
- ADDI (0010011), imem_ready=1 on the first FETCH cycle -> states 1,2,3,5,1; EXEC alu_a_sel=0, alu_b_sel=1; WB rf_we=1, wb_sel=0, pc_sel=0, pc_we=1.
- LW with dmem_ready delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with wb_sel=1; total 8 cycles.
- BEQ with br_taken=1, then again with br_taken=0 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0; no WB state and rf_we never 1.
- JALR then SW -> JALR WB: wb_sel=2, pc_sel=2. SW: MEM dmem_we=1, then pc_we=1 with pc_sel=0 and rf_we=0.
- Opcode 0000000 -> DECODE then TRAP; illegal=1 and imem_req=0 for 20 cycles; clears only on rst. With CTRL_INSTRET_EN, instret stays frozen at its pre-trap count.
